// File: rtl/intersection_pkg.sv
// Shared types and default phase durations for the intersection phase scheduler.
package intersection_pkg;

    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        ALLRED_A    = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4,
        PED_WALK    = 3'd5,
        ALLRED_B    = 3'd6
    } phase_e;

    typedef enum logic {
        SERVE_SIDE = 1'b0,
        SERVE_PED  = 1'b1
    } served_e;

    localparam int DEF_GREEN_MIN = 8;
    localparam int DEF_GREEN_MAX = 30;
    localparam int DEF_YELLOW_T  = 4;
    localparam int DEF_ALLRED_T  = 2;
    localparam int DEF_WALK_T    = 10;
    localparam int DEF_TIMER_W   = 6;

    // Round-robin pick between the two non-main phases; only meaningful when at least one is pending.
    function automatic served_e pick_next(input logic side_pend, input logic ped_pend,
                                          input served_e last);
        if (side_pend && ped_pend) begin
            return (last == SERVE_PED) ? SERVE_SIDE : SERVE_PED;
        end
        return side_pend ? SERVE_SIDE : SERVE_PED;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Saturating up-counter of cycles spent in the current phase; clear restarts it at zero.
module phase_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (count_reg != '1) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Demand-driven main/side/pedestrian phase scheduler with round-robin service of
// latched side and pedestrian requests; lamps are a Moore decode of the phase register.
module intersection_phase_scheduler
    import intersection_pkg::*;
#(
    parameter int GREEN_MIN = DEF_GREEN_MIN,
    parameter int GREEN_MAX = DEF_GREEN_MAX,
    parameter int YELLOW_T  = DEF_YELLOW_T,
    parameter int ALLRED_T  = DEF_ALLRED_T,
    parameter int WALK_T    = DEF_WALK_T,
    parameter int TIMER_W   = DEF_TIMER_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               side_req,
    input  logic               ped_req,
    output logic               main_red,
    output logic               main_yellow,
    output logic               main_green,
    output logic               side_red,
    output logic               side_yellow,
    output logic               side_green,
    output logic               walk,
    output logic               ped_wait,
    output logic [2:0]         phase,
    output logic [TIMER_W-1:0] timer
);

    localparam logic [TIMER_W-1:0] GMIN_LAST   = TIMER_W'(GREEN_MIN - 1);
    localparam logic [TIMER_W-1:0] GMAX_LAST   = TIMER_W'(GREEN_MAX - 1);
    localparam logic [TIMER_W-1:0] YELLOW_LAST = TIMER_W'(YELLOW_T - 1);
    localparam logic [TIMER_W-1:0] ALLRED_LAST = TIMER_W'(ALLRED_T - 1);
    localparam logic [TIMER_W-1:0] WALK_LAST   = TIMER_W'(WALK_T - 1);

    phase_e  state_reg, state_next;
    served_e rr_last_reg, rr_last_next;
    logic    side_pend_reg, side_pend_next;
    logic    ped_pend_reg, ped_pend_next;
    logic    timer_clear;
    served_e pick;

    phase_timer #(
        .W(TIMER_W)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clear(timer_clear),
        .count(timer)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= MAIN_GREEN;
            rr_last_reg   <= SERVE_PED;
            side_pend_reg <= 1'b0;
            ped_pend_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rr_last_reg   <= rr_last_next;
            side_pend_reg <= side_pend_next;
            ped_pend_reg  <= ped_pend_next;
        end
    end

    assign pick = pick_next(side_pend_reg, ped_pend_reg, rr_last_reg);

    always_comb begin
        state_next   = state_reg;
        rr_last_next = rr_last_reg;
        case (state_reg)
            MAIN_GREEN: begin
                if (timer >= GMIN_LAST && (side_pend_reg || ped_pend_reg)) begin
                    state_next = MAIN_YELLOW;
                end
            end
            MAIN_YELLOW: begin
                if (timer == YELLOW_LAST) state_next = ALLRED_A;
            end
            ALLRED_A: begin
                if (timer == ALLRED_LAST) begin
                    // Nothing pending cannot normally happen here; fall back to the return path.
                    if (!side_pend_reg && !ped_pend_reg) begin
                        state_next = ALLRED_B;
                    end else begin
                        rr_last_next = pick;
                        state_next   = (pick == SERVE_SIDE) ? SIDE_GREEN : PED_WALK;
                    end
                end
            end
            SIDE_GREEN: begin
                if (timer == GMAX_LAST || (timer >= GMIN_LAST && !side_req)) begin
                    state_next = SIDE_YELLOW;
                end
            end
            SIDE_YELLOW: begin
                if (timer == YELLOW_LAST) state_next = ALLRED_B;
            end
            PED_WALK: begin
                if (timer == WALK_LAST) state_next = ALLRED_B;
            end
            ALLRED_B: begin
                if (timer == ALLRED_LAST) state_next = MAIN_GREEN;
            end
            default: state_next = MAIN_GREEN;
        endcase
    end

    assign timer_clear = (state_next != state_reg);

    // A new request outside the serving phase beats the clear that happens on entry.
    always_comb begin
        side_pend_next = side_pend_reg;
        ped_pend_next  = ped_pend_reg;
        if (side_req && state_reg != SIDE_GREEN) begin
            side_pend_next = 1'b1;
        end else if (state_next == SIDE_GREEN && state_reg != SIDE_GREEN) begin
            side_pend_next = 1'b0;
        end
        if (ped_req && state_reg != PED_WALK) begin
            ped_pend_next = 1'b1;
        end else if (state_next == PED_WALK && state_reg != PED_WALK) begin
            ped_pend_next = 1'b0;
        end
    end

    always_comb begin
        main_red    = 1'b1;
        main_yellow = 1'b0;
        main_green  = 1'b0;
        side_red    = 1'b1;
        side_yellow = 1'b0;
        side_green  = 1'b0;
        walk        = 1'b0;
        case (state_reg)
            MAIN_GREEN:  begin main_red = 1'b0; main_green  = 1'b1; end
            MAIN_YELLOW: begin main_red = 1'b0; main_yellow = 1'b1; end
            SIDE_GREEN:  begin side_red = 1'b0; side_green  = 1'b1; end
            SIDE_YELLOW: begin side_red = 1'b0; side_yellow = 1'b1; end
            PED_WALK:    walk = 1'b1;
            default:     ;
        endcase
    end

    assign ped_wait = ped_pend_reg;
    assign phase    = state_reg;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Randomized scoreboard bench for intersection_phase_scheduler against a phase-level reference model.
module tb_intersection_phase_scheduler;

    localparam int GMIN = 8;
    localparam int GMAX = 30;
    localparam int YT   = 4;
    localparam int ART  = 2;
    localparam int WT   = 10;
    localparam int TW   = 6;
    localparam int TSAT = (1 << TW) - 1;

    localparam int P_MG  = 0;
    localparam int P_MY  = 1;
    localparam int P_ARA = 2;
    localparam int P_SG  = 3;
    localparam int P_SY  = 4;
    localparam int P_PW  = 5;
    localparam int P_ARB = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          side_req;
    logic          ped_req;
    logic          main_red, main_yellow, main_green;
    logic          side_red, side_yellow, side_green;
    logic          walk, ped_wait;
    logic [2:0]    phase;
    logic [TW-1:0] timer;

    intersection_phase_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .side_req   (side_req),
        .ped_req    (ped_req),
        .main_red   (main_red),
        .main_yellow(main_yellow),
        .main_green (main_green),
        .side_red   (side_red),
        .side_yellow(side_yellow),
        .side_green (side_green),
        .walk       (walk),
        .ped_wait   (ped_wait),
        .phase      (phase),
        .timer      (timer)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [16:0] exp_q[$];

    // Reference model: current phase, cycles spent in it, pending flags, last served (0 side, 1 ped).
    int m_ph;
    int m_t;
    int m_rr;
    bit m_sp;
    bit m_pp;

    task automatic model_reset();
        m_ph = P_MG;
        m_t  = 0;
        m_rr = 1;
        m_sp = 1'b0;
        m_pp = 1'b0;
    endtask

    function automatic logic [16:0] model_out();
        logic [2:0] ml, sl;
        logic       w;
        logic [2:0] ph3;
        logic [5:0] t6;
        ml  = 3'b100;
        sl  = 3'b100;
        w   = 1'b0;
        if (m_ph == P_MG) ml = 3'b001;
        if (m_ph == P_MY) ml = 3'b010;
        if (m_ph == P_SG) sl = 3'b001;
        if (m_ph == P_SY) sl = 3'b010;
        if (m_ph == P_PW) w = 1'b1;
        ph3 = 3'(m_ph);
        t6  = 6'(m_t);
        return {ml, sl, w, m_pp, ph3, t6};
    endfunction

    task automatic model_step(input bit s, input bit p);
        int nph;
        nph = m_ph;
        case (m_ph)
            P_MG:  if (m_t >= GMIN - 1 && (m_sp || m_pp)) nph = P_MY;
            P_MY:  if (m_t == YT - 1) nph = P_ARA;
            P_ARA: if (m_t == ART - 1) begin
                if (m_sp && (!m_pp || m_rr == 1)) begin
                    nph = P_SG; m_rr = 0;
                end else if (m_pp) begin
                    nph = P_PW; m_rr = 1;
                end else begin
                    nph = P_ARB;
                end
            end
            P_SG:  if (m_t == GMAX - 1 || (m_t >= GMIN - 1 && !s)) nph = P_SY;
            P_SY:  if (m_t == YT - 1) nph = P_ARB;
            P_PW:  if (m_t == WT - 1) nph = P_ARB;
            P_ARB: if (m_t == ART - 1) nph = P_MG;
            default: nph = P_MG;
        endcase
        if (s && m_ph != P_SG) m_sp = 1'b1;
        else if (nph == P_SG && m_ph != P_SG) m_sp = 1'b0;
        if (p && m_ph != P_PW) m_pp = 1'b1;
        else if (nph == P_PW && m_ph != P_PW) m_pp = 1'b0;
        if (nph != m_ph) m_t = 0;
        else if (m_t < TSAT) m_t = m_t + 1;
        m_ph = nph;
    endtask

    // Called just after a rising edge: queue this cycle's expectation, drive inputs, advance model.
    task automatic tick(input bit s, input bit p);
        exp_q.push_back(model_out());
        side_req = s;
        ped_req  = p;
        model_step(s, p);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
    endtask

    task automatic wait_phase(input int ph, input bit s, input int budget);
        int k;
        k = 0;
        while (m_ph != ph && k < budget) begin
            tick(s, 1'b0);
            k++;
        end
        n_cmp++;
        if (m_ph != ph) begin
            n_bad++;
            $display("FAIL wait_phase: model phase %0d after %0d cycles, required %0d", m_ph, k, ph);
        end
    endtask

    // Async reset raised between edges; lamps must be main-green/side-red before the next edge.
    task automatic async_reset_check();
        logic [13:0] got;
        side_req = 1'b0;
        ped_req  = 1'b0;
        #1 rst = 1'b1;
        #1;
        got = {main_red, main_yellow, main_green, side_red, side_yellow, side_green,
               walk, ped_wait, phase, timer == '0};
        n_cmp++;
        if (got !== 14'b001_100_0_0_000_1) begin
            n_bad++;
            $display("FAIL async_reset: got %b required %b", got, 14'b001_100_0_0_000_1);
        end
        #1 rst = 1'b0;
        model_reset();
    endtask

    int bad_prints = 0;

    always @(negedge clk) begin
        logic [16:0] e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {main_red, main_yellow, main_green, side_red, side_yellow, side_green,
                 walk, ped_wait, phase, timer};
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                if (bad_prints < 40) begin
                    bad_prints++;
                    $display("FAIL outputs cycle %0d: got lamps=%b walk=%b wait=%b ph=%0d t=%0d required lamps=%b walk=%b wait=%b ph=%0d t=%0d",
                             cyc, a[16:11], a[10], a[9], a[8:6], a[5:0],
                             e[16:11], e[10], e[9], e[8:6], e[5:0]);
                end
            end
            n_cmp++;
            if (!($onehot({main_red, main_yellow, main_green}) &&
                  $onehot({side_red, side_yellow, side_green}) &&
                  (main_red || side_red) && (!walk || (main_red && side_red)))) begin
                n_bad++;
                if (bad_prints < 40) begin
                    bad_prints++;
                    $display("FAIL lamp_exclusive cycle %0d: got main=%b side=%b walk=%b required one-hot, one road red, walk only on all-red",
                             cyc, {main_red, main_yellow, main_green},
                             {side_red, side_yellow, side_green}, walk);
                end
            end
        end
    end

    initial begin
        rst      = 1'b1;
        side_req = 1'b0;
        ped_req  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Quiet main road: rests in green, timer saturates.
        run_idle(100);

        // Single side request pulse after a fresh reset.
        async_reset_check();
        tick(1'b1, 1'b0);
        run_idle(60);

        // Continuous side demand hits the max-green limit repeatedly.
        for (int i = 0; i < 120; i++) tick(1'b1, 1'b0);
        run_idle(40);

        // Pedestrian pulse during main yellow.
        tick(1'b1, 1'b0);
        wait_phase(P_MY, 1'b0, 40);
        tick(1'b0, 1'b1);
        run_idle(60);

        // Simultaneous requests from reset: side first, then walk.
        async_reset_check();
        tick(1'b1, 1'b1);
        run_idle(80);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            tick($urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0);
        end
        run_idle(60);

        // Reset mid side green with a pedestrian still waiting.
        async_reset_check();
        tick(1'b1, 1'b1);
        wait_phase(P_SG, 1'b1, 60);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        async_reset_check();
        run_idle(20);

        for (int i = 0; i < 800; i++) begin
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end
        run_idle(40);

        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
